// File: rtl/bcd_display_encoder.sv
// Sequential binary-to-BCD encoder (shift-and-add-3, one bit per clock) with start/done handshake.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module bcd_display_encoder #(
  parameter int IN_W   = 14,
  parameter int DIGITS = 4
) (
  input  logic                  ADC_CLK_10,
  input  logic                  clear,
  input  logic                  start,
  input  logic [IN_W-1:0]       bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow,
  output logic [DIGITS-1:0]     blank
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SW    = BCD_W + IN_W;
  localparam int CW    = $clog2(IN_W + 1);
  localparam int MAXV  = 10**DIGITS - 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state, state_nxt;
  logic [SW-1:0]     scratch;
  logic [SW-1:0]     scratch_shift;
  logic [CW-1:0]     count;
  logic              ovf_q;
  logic              accept;
  logic [BCD_W-1:0]  result;

  // A new request is taken in IDLE and also in DONE, which gives back-to-back conversions.
  assign accept = start && (state != SHIFT);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge ADC_CLK_10 or posedge clear) begin
    if (clear) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (count == CW'(1)) state_nxt = DONE;
      DONE:    state_nxt = accept ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SHIFT);
  end

  // Add-3 correction of every BCD field >= 5, then shift left by one, all in one cycle.
  always_comb begin
    logic [SW-1:0] corr;
    corr = scratch;
    for (int k = 0; k < DIGITS; k++) begin
      if (scratch[IN_W + 4*k +: 4] >= 4'd5)
        corr[IN_W + 4*k +: 4] = scratch[IN_W + 4*k +: 4] + 4'd3;
    end
    scratch_shift = {corr[SW-2:0], 1'b0};
  end

  assign result = ovf_q ? {DIGITS{4'h9}} : scratch[SW-1:IN_W];

  always_ff @(posedge ADC_CLK_10 or posedge clear) begin
    if (clear) begin
      scratch <= '0;
      count   <= '0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      scratch <= {{BCD_W{1'b0}}, bin_in};
      count   <= CW'(IN_W);
      ovf_q   <= ({{(32-IN_W){1'b0}}, bin_in} > 32'(MAXV));
    end else if (state == SHIFT) begin
      scratch <= scratch_shift;
      count   <= count - CW'(1);
    end
  end

  // Results are published on the edge leaving DONE; they hold until the next such edge.
  always_ff @(posedge ADC_CLK_10 or posedge clear) begin
    if (clear) begin
      done     <= 1'b0;
      bcd_out  <= '0;
      overflow <= 1'b0;
    end else begin
      done <= (state == DONE);
      if (state == DONE) begin
        bcd_out  <= result;
        overflow <= ovf_q;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] blank_nxt;

  // Digit k>0 is blank when it and every higher digit are zero; digit 0 always shows.
  always_comb begin
    logic zero_run;
    blank_nxt = '0;
    zero_run  = 1'b1;
    for (int k = DIGITS-1; k > 0; k--) begin
      zero_run     = zero_run & (result[4*k +: 4] == 4'd0);
      blank_nxt[k] = zero_run & ~ovf_q;
    end
  end

  always_ff @(posedge ADC_CLK_10 or posedge clear) begin
    if (clear)              blank <= '0;
    else if (state == DONE) blank <= blank_nxt;
  end
`else
  assign blank = '0;
`endif

endmodule

// File: tb/tb_bcd_display_encoder.sv
// Self-checking bench for bcd_display_encoder: vector table, random values against a
// decimal-arithmetic model, and hand-written busy-start, abort and back-to-back sequences.
module tb_bcd_display_encoder;

  localparam int IN_W   = 14;
  localparam int DIGITS = 4;
  localparam int LAT    = IN_W + 1;

  logic        ADC_CLK_10 = 1'b0;
  logic        clear;
  logic        start;
  logic [13:0] bin_in;
  logic        busy;
  logic        done;
  logic [15:0] bcd_out;
  logic        overflow;
  logic [3:0]  blank;

  int checks = 0;
  int errors = 0;

  bcd_display_encoder #(.IN_W(IN_W), .DIGITS(DIGITS)) dut (
    .ADC_CLK_10 (ADC_CLK_10),
    .clear      (clear),
    .start      (start),
    .bin_in     (bin_in),
    .busy       (busy),
    .done       (done),
    .bcd_out    (bcd_out),
    .overflow   (overflow),
    .blank      (blank)
  );

  always #5 ADC_CLK_10 = ~ADC_CLK_10;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: plain decimal arithmetic on the saturated value.
  function automatic logic [15:0] model_bcd(input int v);
    logic [15:0] r;
    int x;
    x = (v > 9999) ? 9999 : v;
    r = '0;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [3:0] model_blank(input int v);
    logic [3:0] b;
    b = '0;
`ifdef LEADING_ZERO_BLANK_EN
    if (v <= 9999)
      for (int k = 1; k < DIGITS; k++) b[k] = (v < 10**k);
`endif
    return b;
  endfunction

  // Start one conversion and wait (bounded) for done; returns latency in edges after acceptance.
  task automatic convert(input logic [13:0] v, output int lat);
    @(negedge ADC_CLK_10);
    bin_in = v;
    start  = 1'b1;
    @(posedge ADC_CLK_10);
    #1;
    start  = 1'b0;
    bin_in = ~v;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge ADC_CLK_10);
      #1;
      if (n == 5) check("busy_mid", busy, 1'b1);
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic check_result(input string tag, input int v, input int lat);
    check({tag, "_lat"}, lat, LAT);
    check({tag, "_bcd"}, bcd_out, model_bcd(v));
    check({tag, "_ovf"}, overflow, (v > 9999));
    check({tag, "_blank"}, blank, model_blank(v));
    @(posedge ADC_CLK_10);
    #1;
    check({tag, "_done_pulse"}, done, 1'b0);
    check({tag, "_hold"}, bcd_out, model_bcd(v));
  endtask

  typedef struct {
    logic [13:0] val;
    logic [15:0] bcd;
    logic        ovf;
    logic [3:0]  blank_en;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int lat;
    int v;
    int ndone;
    int first_n;
    int second_n;
    logic [15:0] first_bcd;
    logic [15:0] second_bcd;
    logic [3:0]  exp_bl;

    vecs[0] = '{14'd0,     16'h0000, 1'b0, 4'b1110};
    vecs[1] = '{14'd1234,  16'h1234, 1'b0, 4'b0000};
    vecs[2] = '{14'd9999,  16'h9999, 1'b0, 4'b0000};
    vecs[3] = '{14'd10000, 16'h9999, 1'b1, 4'b0000};
    vecs[4] = '{14'd16383, 16'h9999, 1'b1, 4'b0000};
    vecs[5] = '{14'd7,     16'h0007, 1'b0, 4'b1110};
    vecs[6] = '{14'd56,    16'h0056, 1'b0, 4'b1100};
    vecs[7] = '{14'd100,   16'h0100, 1'b0, 4'b1000};
    vecs[8] = '{14'd1000,  16'h1000, 1'b0, 4'b0000};

    clear  = 1'b1;
    start  = 1'b0;
    bin_in = '0;
    #27;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_bcd", bcd_out, 16'h0000);
    check("rst_ovf", overflow, 1'b0);
    check("rst_blank", blank, 4'b0000);
    @(negedge ADC_CLK_10);
    clear = 1'b0;

    // Vector table
    foreach (vecs[i]) begin
`ifdef LEADING_ZERO_BLANK_EN
      exp_bl = vecs[i].blank_en;
`else
      exp_bl = 4'b0000;
`endif
      convert(vecs[i].val, lat);
      check($sformatf("vec%0d_lat", i), lat, LAT);
      check($sformatf("vec%0d_bcd", i), bcd_out, vecs[i].bcd);
      check($sformatf("vec%0d_ovf", i), overflow, vecs[i].ovf);
      check($sformatf("vec%0d_blank", i), blank, exp_bl);
      @(posedge ADC_CLK_10);
      #1;
      check($sformatf("vec%0d_done_pulse", i), done, 1'b0);
    end

    // Random values against the model, with extra weight near the saturation boundary
    for (int i = 0; i < 30; i++) begin
      if (i % 3 == 0) v = 9990 + int'($urandom_range(0, 20));
      else            v = int'($urandom_range(0, 16383));
      convert(14'(v), lat);
      check_result($sformatf("rnd%0d_v%0d", i, v), v, lat);
    end

    // start while busy is ignored
    @(negedge ADC_CLK_10);
    bin_in = 14'd4321;
    start  = 1'b1;
    @(posedge ADC_CLK_10);
    #1;
    start = 1'b0;
    ndone = 0;
    first_n = -1;
    first_bcd = '0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge ADC_CLK_10);
      #1;
      if (n == 4) begin
        start  = 1'b1;
        bin_in = 14'd42;
      end
      if (n == 5) begin
        check("busy_start_busy", busy, 1'b1);
        start = 1'b0;
      end
      if (done) begin
        ndone++;
        if (first_n < 0) begin
          first_n   = n;
          first_bcd = bcd_out;
        end
      end
    end
    check("busy_start_ndone", ndone, 1);
    check("busy_start_lat", first_n, LAT);
    check("busy_start_bcd", first_bcd, 16'h4321);

    // clear mid-conversion aborts with no done
    @(negedge ADC_CLK_10);
    bin_in = 14'd777;
    start  = 1'b1;
    @(posedge ADC_CLK_10);
    #1;
    start = 1'b0;
    for (int n = 1; n <= 7; n++) @(posedge ADC_CLK_10);
    #1;
    clear = 1'b1;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_bcd", bcd_out, 16'h0000);
    check("abort_ovf", overflow, 1'b0);
    check("abort_blank", blank, 4'b0000);
    @(negedge ADC_CLK_10);
    clear = 1'b0;
    ndone = 0;
    for (int n = 0; n < 25; n++) begin
      @(posedge ADC_CLK_10);
      #1;
      if (done) ndone++;
    end
    check("abort_no_done", ndone, 0);
    convert(14'd8, lat);
    check_result("after_abort", 8, lat);

    // start held high: back-to-back conversions 15 cycles apart
    @(negedge ADC_CLK_10);
    bin_in = 14'd56;
    start  = 1'b1;
    @(posedge ADC_CLK_10);
    #1;
    bin_in = 14'd90;
    ndone = 0;
    first_n = -1;
    second_n = -1;
    first_bcd = '0;
    second_bcd = '0;
    for (int n = 1; n <= 45; n++) begin
      @(posedge ADC_CLK_10);
      #1;
      if (n == 25) check("b2b_hold", bcd_out, 16'h0056);
      if (done) begin
        ndone++;
        if (first_n < 0) begin
          first_n   = n;
          first_bcd = bcd_out;
          check("b2b_blank1", blank, model_blank(56));
          start = 1'b0;
        end else if (second_n < 0) begin
          second_n   = n;
          second_bcd = bcd_out;
          check("b2b_blank2", blank, model_blank(90));
        end
      end
    end
    check("b2b_ndone", ndone, 2);
    check("b2b_lat1", first_n, LAT);
    check("b2b_gap", second_n - first_n, LAT);
    check("b2b_bcd1", first_bcd, 16'h0056);
    check("b2b_bcd2", second_bcd, 16'h0090);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
